// File: rtl/xalu_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide unit.
// Imported by the unit top and its latency counter.
package xalu_pkg;

    typedef enum logic [2:0] {
        XALU_MULT  = 3'b000,
        XALU_MULTU = 3'b001,
        XALU_DIV   = 3'b010,
        XALU_DIVU  = 3'b011,
        XALU_MTHI  = 3'b100,
        XALU_MTLO  = 3'b101
    } xalu_op_e;

    localparam logic READ_LO = 1'b0;
    localparam logic READ_HI = 1'b1;

    localparam int XALU_DEF_WIDTH       = 32;
    localparam int XALU_DEF_MULT_CYCLES = 5;
    localparam int XALU_DEF_DIV_CYCLES  = 10;

    function automatic int xalu_max(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/xalu_latency_counter.sv
// Loadable down-counter modelling op latency.
// busy while non-zero; done marks the final busy cycle.
module xalu_latency_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          busy,
    output logic          done
);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (busy) begin
            count <= count - CW'(1);
        end
    end

    assign busy = (count != '0);
    assign done = (count == CW'(1));

endmodule

// File: rtl/xalu_hilo_unit.sv
// Multi-cycle MULT/DIV unit owning HI/LO for the EX stage.
// Results are computed at issue, held pending, committed when the latency expires.
module xalu_hilo_unit
    import xalu_pkg::*;
#(
    parameter int WIDTH       = XALU_DEF_WIDTH,
    parameter int MULT_CYCLES = XALU_DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = XALU_DEF_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             read_sel,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(xalu_max(MULT_CYCLES, DIV_CYCLES) + 1);

    logic accept;
    logic is_mult;
    logic is_div;
    logic is_signed;
    logic is_mthi;
    logic is_mtlo;
    logic done;
    logic load;
    logic [CW-1:0] load_val;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   dvd;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH-1:0]   uq;
    logic [WIDTH-1:0]   ur;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    logic [WIDTH-1:0] pending_hi;
    logic [WIDTH-1:0] pending_lo;
    logic             pending_wr;

    always_comb begin
        is_mult   = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        case (op)
            XALU_MULT:  begin is_mult = 1'b1; is_signed = 1'b1; end
            XALU_MULTU: is_mult = 1'b1;
            XALU_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            XALU_DIVU:  is_div = 1'b1;
            XALU_MTHI:  is_mthi = 1'b1;
            XALU_MTLO:  is_mtlo = 1'b1;
            default:    ;
        endcase
    end

    assign accept   = start && !busy;
    assign load     = accept && (is_mult || is_div);
    assign load_val = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

    // Sign-extending to 2W makes the low 2W bits of the product correct for signed.
    always_comb begin
        if (is_signed) begin
            prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        end else begin
            prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        end
    end

    // Signed divide on magnitudes; MIN/-1 wraps back to MIN naturally.
    always_comb begin
        abs_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        abs_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
        dvd   = is_signed ? abs_a : a;
        dvs   = is_signed ? abs_b : b;
        if (dvs == '0) begin
            dvs = WIDTH'(1);
        end
        uq  = dvd / dvs;
        ur  = dvd % dvs;
        quo = uq;
        rem = ur;
        if (is_signed && (a[WIDTH-1] ^ b[WIDTH-1])) begin
            quo = ~uq + WIDTH'(1);
        end
        if (is_signed && a[WIDTH-1]) begin
            rem = ~ur + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi         <= '0;
            lo         <= '0;
            pending_hi <= '0;
            pending_lo <= '0;
            pending_wr <= 1'b0;
        end else begin
            if (accept && is_mult) begin
                pending_hi <= prod[2*WIDTH-1:WIDTH];
                pending_lo <= prod[WIDTH-1:0];
                pending_wr <= 1'b1;
            end
            if (accept && is_div) begin
                pending_hi <= rem;
                pending_lo <= quo;
                pending_wr <= (b != '0);
            end
            if (accept && is_mthi) begin
                hi <= a;
            end
            if (accept && is_mtlo) begin
                lo <= a;
            end
            if (done && pending_wr) begin
                hi <= pending_hi;
                lo <= pending_lo;
            end
        end
    end

    xalu_latency_counter #(
        .CW(CW)
    ) u_latency (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .load_val(load_val),
        .busy    (busy),
        .done    (done)
    );

    assign result = (read_sel == READ_HI) ? hi : lo;

endmodule

// File: tb/tb_xalu_hilo_unit.sv
// Directed bench for xalu_hilo_unit: vector table plus hand sequences
// for overlap, divide-by-zero and reset abort.
module tb_xalu_hilo_unit;
    import xalu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b111;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        read_sel = 1'b0;
    logic        busy;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xalu_hilo_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .read_sel(read_sel),
        .busy    (busy),
        .result  (result),
        .hi      (hi),
        .lo      (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'b111;
    endtask

    // Counts busy cycles seen at negedges; returns at the first idle one.
    task automatic count_busy(input int init, output int n);
        n = init;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!busy) return;
            n++;
        end
        n = -1;
    endtask

    task automatic check_regs(input string name, input logic [31:0] eh,
                              input logic [31:0] el);
        check({name, " hi"}, 64'(hi), 64'(eh));
        check({name, " lo"}, 64'(lo), 64'(el));
        read_sel = READ_HI;
        #1;
        check({name, " result_hi"}, 64'(result), 64'(eh));
        read_sel = READ_LO;
        #1;
        check({name, " result_lo"}, 64'(result), 64'(el));
    endtask

    initial begin
        int n;

        vecs[0] = '{XALU_MULT,  32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vecs[1] = '{XALU_DIVU,  32'd7, 32'd2, 32'd1, 32'd3, 10};
        vecs[2] = '{XALU_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3] = '{XALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        vecs[4] = '{XALU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10};
        vecs[5] = '{XALU_DIV,   32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10};
        vecs[6] = '{XALU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 5};
        vecs[7] = '{XALU_DIVU,  32'hFFFFFFFF, 32'd16, 32'd15, 32'h0FFFFFFF, 10};

        // Reset
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check_regs("reset", 32'h0, 32'h0);

        // Table
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            count_busy(0, n);
            check($sformatf("vec%0d cycles", i), 64'(n), 64'(vecs[i].cycles));
            check_regs($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
        end

        // Start while busy is ignored
        issue(XALU_MULTU, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        op = XALU_DIV;
        a = 32'd100;
        b = 32'd10;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 3'b111;
        count_busy(2, n);
        check("overlap cycles", 64'(n), 64'd5);
        check_regs("overlap", 32'd0, 32'd12);
        @(negedge clk);
        check("overlap idle", 64'(busy), 64'd0);

        // MTHI/MTLO then divide by zero
        issue(XALU_MTHI, 32'hAAAA0000, 32'd0);
        @(negedge clk);
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi lo kept", 64'(lo), 64'd12);
        issue(XALU_MTLO, 32'h00005555, 32'd0);
        @(negedge clk);
        check("mtlo busy", 64'(busy), 64'd0);
        check_regs("mt", 32'hAAAA0000, 32'h00005555);
        issue(XALU_DIV, 32'd100, 32'd0);
        count_busy(0, n);
        check("div0 cycles", 64'(n), 64'd10);
        check_regs("div0", 32'hAAAA0000, 32'h00005555);

        // Unknown op
        issue(3'b110, 32'd9, 32'd9);
        @(negedge clk);
        check("nop busy", 64'(busy), 64'd0);
        check_regs("nop", 32'hAAAA0000, 32'h00005555);

        // Reset aborts an in-flight multiply
        issue(XALU_MULT, 32'd7, 32'd6);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort busy before", 64'(busy), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        check("abort busy", 64'(busy), 64'd0);
        check_regs("abort", 32'h0, 32'h0);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("abort late busy", 64'(busy), 64'd0);
        check_regs("abort late", 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xalu_hilo_unit.md
Name: xalu_hilo_unit

Overview:
Parametrised multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS core. It owns the HI/LO registers and supports MULT/MULTU/DIV/DIVU with configurable latency, plus MTHI/MTLO. It exposes a busy flag for the hazard unit to stall MFHI/MFLO and further mult/div ops. It replaces the old combinational HI/LO select with a registered, latency-modelled unit that has an integrated read select.

Parameters:
WIDTH, 32, operand and HI/LO register width
MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (clk and reset named as elsewhere in the core; 0 = reset)
start  input  1  issue strobe for the op on op, valid for one cycle
op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op
a  input  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data)
b  input  WIDTH  rt operand (divisor / multiplier)
read_sel  input  1  0 selects LO, 1 selects HI on result
busy  output  1  operation in flight
result  output  WIDTH  combinational read of the selected register: LO or HI
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (reset==0 at an edge): hi=0, lo=0, busy=0, the counter and pending results are cleared, and any in-flight op is aborted with no write. Reset has priority over every other input.
- Accept: start=1 and busy=0 at an edge. When busy=1, start is ignored entirely, with no state change; the hazard unit must stall.
- MULT/MULTU on accept: a full 2*WIDTH product (signed or unsigned) is latched into pending registers. The counter loads MULT_CYCLES and busy=1 from the next cycle.
- DIV/DIVU on accept: the quotient and remainder are latched into pending registers. The counter loads DIV_CYCLES.
- Signed divide truncates toward zero, and the remainder takes the sign of the dividend. For MIN / -1, the quotient is MIN and the remainder is 0 (wrap).
- Divide by zero (b==0): the op still occupies DIV_CYCLES of busy, but HI/LO are left unchanged at completion.
- Counting: the counter decrements each cycle while busy. On the edge where the counter==1, hi<=pending_hi and lo<=pending_lo, the counter goes to 0, and busy=0 from the next cycle.
  - Latency: with accept at edge T, busy is high for exactly N cycles and the new HI/LO are visible after edge T+N.
- Product mapping: hi=product[2W-1:W], lo=product[W-1:0]. For divide: lo=quotient, hi=remainder.
- MTHI/MTLO on accept: the target register is written with a at the same edge. These ops take no busy cycles and leave the other register unchanged.
- result = read_sel ? hi : lo, using committed registers only. Pending values are never forwarded.
- Unknown op with start: no-op and busy stays 0.
- A start arriving in the same cycle that busy falls (counter already 0) is accepted normally. There is no back-to-back overlap.

Decomposition:
- Shared package xalu_pkg holds:
  - the op encodings (XALU_MULT…XALU_MTLO),
  - the READ_LO/READ_HI constants,
  - the default latency constants.
- One natural sub-module, xalu_latency_counter: a loadable down-counter with a done pulse, reused for both latencies.
- The arithmetic stays inline.

Test Plan:
- Reset low for 2 cycles, then high -> hi=0, lo=0, busy=0, result=0.
- MULT a=0xFFFFFFFD (-3), b=5 -> busy high exactly 5 cycles. Afterwards hi=0xFFFFFFFF, lo=0xFFFFFFF1. With read_sel=1, result=0xFFFFFFFF.
- DIVU a=7, b=2 -> 10 busy cycles, then lo=3, hi=1. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- MULTU a=3, b=4, then a second start with DIV 100/10 issued 2 cycles later while busy -> the second start is ignored. Final lo=12, hi=0, and busy falls after 5 cycles.
- Preload MTHI a=0xAAAA0000 and MTLO a=0x5555 (each with no busy), then DIV b=0 -> busy for 10 cycles, and afterwards hi=0xAAAA0000, lo=0x5555 (unchanged).
- Start MULT, then assert reset low on the 3rd busy cycle -> the next cycle shows busy=0, hi=0, lo=0, and no late write occurs after reset is released.
